// File: rtl/mem_access_stage.sv
// MIPS memory stage: EX/MEM register, req/ack data-memory handshake with front-end stall,
// load lane extraction, branch resolution and the MEM/WB register.
module mem_access_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite_in,
  input  logic              MemWrite_in,
  input  logic              MemRead_in,
  input  logic              MemToReg_in,
  input  logic              branch_in,
  input  logic              zero_in,
  input  logic [1:0]        load_mode_in,
  input  logic [4:0]        writebackDestination_in,
  input  logic [31:0]       aluResult_in,
  input  logic [31:0]       rt_in,
  input  logic [31:0]       pc_in,
  input  logic              flush_in,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_byte_en,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              pc_src_out,
  output logic [31:0]       branch_target_out,
  output logic              wb_RegWrite,
  output logic              wb_MemToReg,
  output logic [4:0]        wb_dest,
  output logic [31:0]       wb_read_data,
  output logic [31:0]       wb_alu_result
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]  state;
  logic        reg_regwrite, reg_memwrite, reg_memread, reg_memtoreg, reg_branch, reg_zero;
  logic [1:0]  reg_load_mode;
  logic [4:0]  reg_dest;
  logic [31:0] reg_alu, reg_rt, reg_pc;
  logic        is_load;
  logic [15:0] lane16;
  logic [7:0]  lane8;
  logic [31:0] load_data;

  assign stall_out         = (state == ACCESS) & ~mem_ack;
  assign mem_req           = (state == ACCESS);
  assign mem_we            = reg_memwrite;
  assign mem_addr          = {reg_alu[ADDR_W-1:2], 2'b00};
  assign mem_wdata         = reg_rt;
  assign mem_byte_en       = {4{reg_memwrite}};
  assign pc_src_out        = reg_branch & reg_zero;
  assign branch_target_out = reg_pc;
  // A store wins over a simultaneous read request, so it never produces load data.
  assign is_load           = reg_memread & ~reg_memwrite;

  always_comb begin
    lane16    = reg_alu[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    lane8     = '0;
    load_data = '0;
    case (reg_alu[1:0])
      2'd0:    lane8 = mem_rdata[7:0];
      2'd1:    lane8 = mem_rdata[15:8];
      2'd2:    lane8 = mem_rdata[23:16];
      default: lane8 = mem_rdata[31:24];
    endcase
    case (reg_load_mode)
      2'b00:   load_data = mem_rdata;
      2'b01:   load_data = {{16{lane16[15]}}, lane16};
      2'b10:   load_data = {{24{lane8[7]}}, lane8};
      default: load_data = {24'd0, lane8};
    endcase
  end

  // EX/MEM register and access FSM advance together; a flush zeroes only the control bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      reg_regwrite  <= 1'b0;
      reg_memwrite  <= 1'b0;
      reg_memread   <= 1'b0;
      reg_memtoreg  <= 1'b0;
      reg_branch    <= 1'b0;
      reg_zero      <= 1'b0;
      reg_load_mode <= '0;
      reg_dest      <= '0;
      reg_alu       <= '0;
      reg_rt        <= '0;
      reg_pc        <= '0;
    end else if (!stall_out) begin
      state         <= ((MemWrite_in | MemRead_in) & ~flush_in) ? ACCESS : IDLE;
      reg_regwrite  <= RegWrite_in & ~flush_in;
      reg_memwrite  <= MemWrite_in & ~flush_in;
      reg_memread   <= MemRead_in & ~flush_in;
      reg_memtoreg  <= MemToReg_in & ~flush_in;
      reg_branch    <= branch_in & ~flush_in;
      reg_zero      <= zero_in & ~flush_in;
      reg_load_mode <= load_mode_in;
      reg_dest      <= writebackDestination_in;
      reg_alu       <= aluResult_in;
      reg_rt        <= rt_in;
      reg_pc        <= pc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_RegWrite   <= 1'b0;
      wb_MemToReg   <= 1'b0;
      wb_dest       <= '0;
      wb_read_data  <= '0;
      wb_alu_result <= '0;
    end else if (stall_out) begin
      wb_RegWrite   <= 1'b0;
      wb_MemToReg   <= 1'b0;
    end else begin
      wb_RegWrite   <= reg_regwrite;
      wb_MemToReg   <= reg_memtoreg;
      wb_dest       <= reg_dest;
      wb_alu_result <= reg_alu;
      wb_read_data  <= is_load ? load_data : '0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed literal checks plus randomized traffic compared
// every cycle against a transaction-level model of the memory stage.
module tb_mem_access_stage;

  typedef struct packed {
    logic        rw, mw, mr, m2r, br, z;
    logic [1:0]  lm;
    logic [4:0]  dest;
    logic [31:0] alu, rt, pc;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RegWrite_in = 1'b0, MemWrite_in = 1'b0, MemRead_in = 1'b0, MemToReg_in = 1'b0;
  logic        branch_in = 1'b0, zero_in = 1'b0, flush_in = 1'b0, mem_ack = 1'b0;
  logic [1:0]  load_mode_in = '0;
  logic [4:0]  writebackDestination_in = '0;
  logic [31:0] aluResult_in = '0, rt_in = '0, pc_in = '0, mem_rdata = '0;
  logic        stall_out, mem_req, mem_we, pc_src_out, wb_RegWrite, wb_MemToReg;
  logic [31:0] mem_addr, mem_wdata, branch_target_out, wb_read_data, wb_alu_result;
  logic [3:0]  mem_byte_en;
  logic [4:0]  wb_dest;

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
    .MemToReg_in(MemToReg_in), .branch_in(branch_in), .zero_in(zero_in),
    .load_mode_in(load_mode_in), .writebackDestination_in(writebackDestination_in),
    .aluResult_in(aluResult_in), .rt_in(rt_in), .pc_in(pc_in), .flush_in(flush_in),
    .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pc_src_out(pc_src_out), .branch_target_out(branch_target_out),
    .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg), .wb_dest(wb_dest),
    .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: the op sitting in the memory stage, whether it still owns the memory, and
  // what write-back currently shows.
  op_t         m_ex = '0;
  bit          m_access = 0;
  bit          m_wb_rw = 0, m_wb_m2r = 0;
  logic [4:0]  m_wb_dest = '0;
  logic [31:0] m_wb_alu = '0, m_wb_rd = '0;
  int          wait_left = 0;
  int          wait_q[$];
  bit          model_valid = 0;
  bit          exp_stall = 0;
  bit          accepted = 0;

  op_t         ex_next = '0;
  bit          flush_next = 0;
  bit          rst_next = 0;
  bit          rdata_fixed = 0;
  logic [31:0] rdata_val = '0;

  function automatic logic [31:0] load_value(logic [1:0] mode, logic [31:0] addr, logic [31:0] word);
    int unsigned off = addr % 4;
    int unsigned v;
    case (mode)
      2'd0: v = word;
      2'd1: begin
        v = (word >> (16 * (off / 2))) & 32'hFFFF;
        if (v >= 32'h8000) v = v + 32'hFFFF0000;
      end
      2'd2: begin
        v = (word >> (8 * off)) & 32'hFF;
        if (v >= 32'h80) v = v + 32'hFFFFFF00;
      end
      default: v = (word >> (8 * off)) & 32'hFF;
    endcase
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_ex(op_t op);
    RegWrite_in = op.rw; MemWrite_in = op.mw; MemRead_in = op.mr; MemToReg_in = op.m2r;
    branch_in = op.br; zero_in = op.z; load_mode_in = op.lm;
    writebackDestination_in = op.dest; aluResult_in = op.alu; rt_in = op.rt; pc_in = op.pc;
  endtask

  task automatic cycle();
    op_t cur;
    bit  is_load;
    @(negedge clk);
    rst_n = rst_next;
    mem_ack = m_access ? (wait_left == 0) : ($urandom_range(0, 3) == 0);
    mem_rdata = rdata_fixed ? rdata_val : $urandom;
    exp_stall = m_access && !mem_ack;
    accepted = !exp_stall && rst_n;
    flush_in = flush_next;
    if (!exp_stall) drive_ex(ex_next);
    #1;
    if (model_valid) begin
      chk("mem_req", mem_req, m_access);
      chk("stall_out", stall_out, exp_stall);
      chk("mem_we", mem_we, m_ex.mw);
      if (m_access) begin
        chk("mem_addr", mem_addr, m_ex.alu & 32'hFFFF_FFFC);
        if (m_ex.mw) begin
          chk("mem_wdata", mem_wdata, m_ex.rt);
          chk("mem_byte_en", mem_byte_en, 4'hF);
        end
      end
      chk("pc_src_out", pc_src_out, m_ex.br & m_ex.z);
      if (m_ex.br) chk("branch_target", branch_target_out, m_ex.pc);
      chk("wb_RegWrite", wb_RegWrite, m_wb_rw);
      chk("wb_MemToReg", wb_MemToReg, m_wb_m2r);
      if (m_wb_rw || m_wb_m2r) begin
        chk("wb_dest", wb_dest, m_wb_dest);
        chk("wb_alu_result", wb_alu_result, m_wb_alu);
        chk("wb_read_data", wb_read_data, m_wb_rd);
      end
    end
    // Advance the model to what the next clock edge must produce.
    if (!rst_n) begin
      m_ex = '0; m_access = 0; wait_left = 0;
      m_wb_rw = 0; m_wb_m2r = 0; m_wb_dest = '0; m_wb_alu = '0; m_wb_rd = '0;
      model_valid = 1;
    end else if (exp_stall) begin
      m_wb_rw = 0; m_wb_m2r = 0;
      wait_left--;
    end else begin
      is_load = m_ex.mr && !m_ex.mw;
      m_wb_rw = m_ex.rw; m_wb_m2r = m_ex.m2r; m_wb_dest = m_ex.dest; m_wb_alu = m_ex.alu;
      m_wb_rd = is_load ? load_value(m_ex.lm, m_ex.alu, mem_rdata) : 32'd0;
      cur = ex_next;
      if (flush_next) begin
        cur.rw = 0; cur.mw = 0; cur.mr = 0; cur.m2r = 0; cur.br = 0; cur.z = 0;
      end
      m_ex = cur;
      m_access = cur.mw || cur.mr;
      if (m_access) wait_left = (wait_q.size() > 0) ? wait_q.pop_front() : int'($urandom_range(0, 3));
    end
  endtask

  task automatic issue(op_t op, bit fl);
    ex_next = op;
    flush_next = fl;
    accepted = 0;
    for (int i = 0; i < 20 && !accepted; i++) cycle();
    if (!accepted) begin
      total++; bad++;
      $display("FAIL issue_timeout: got stalled expected accepted at %0t", $time);
    end
    ex_next = '0;
    flush_next = 0;
  endtask

  function automatic op_t rand_op();
    op_t op = '0;
    int  kind = int'($urandom_range(0, 5));
    op.dest = 5'($urandom); op.alu = $urandom; op.rt = $urandom; op.pc = $urandom;
    op.lm = 2'($urandom); op.z = 1'($urandom_range(0, 1));
    case (kind)
      0, 1: op.rw = 1'($urandom_range(0, 1));
      2: begin op.mr = 1; op.m2r = 1; op.rw = 1; end
      3: op.mw = 1;
      4: begin op.mw = 1; op.mr = 1; op.rw = 1'($urandom_range(0, 1)); end
      default: op.br = 1;
    endcase
    return op;
  endfunction

  initial begin
    op_t         op;
    int          stalls;
    logic [1:0]  lm_t[5]  = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b00};
    int          off_t[5] = '{1, 3, 2, 2, 0};
    logic [31:0] exp_t[5] = '{32'h0000007F, 32'hFFFFFF80, 32'h000000FF, 32'hFFFF80FF, 32'h80FF7F01};

    rst_next = 0;
    cycle(); cycle();
    rst_next = 1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_pc_src", pc_src_out, 0);
    chk("rst_target", branch_target_out, 0);
    chk("rst_wb_rw", wb_RegWrite, 0);
    chk("rst_wb_m2r", wb_MemToReg, 0);
    chk("rst_wb_dest", wb_dest, 0);
    chk("rst_wb_rd", wb_read_data, 0);
    chk("rst_wb_alu", wb_alu_result, 0);

    op = '0; op.rw = 1; op.dest = 5; op.alu = 32'h1234;
    issue(op, 0);
    cycle();
    chk("alu_no_req", mem_req, 0);
    cycle();
    chk("alu_wb_rw", wb_RegWrite, 1);
    chk("alu_wb_dest", wb_dest, 5);
    chk("alu_wb_result", wb_alu_result, 32'h1234);

    op = '0; op.mw = 1; op.alu = 32'h103; op.rt = 32'hDEADBEEF;
    wait_q.push_back(2);
    issue(op, 0);
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (i == 0) begin
        chk("st_req", mem_req, 1);
        chk("st_addr", mem_addr, 32'h100);
        chk("st_we", mem_we, 1);
        chk("st_be", mem_byte_en, 4'hF);
        chk("st_wdata", mem_wdata, 32'hDEADBEEF);
      end
      if (stall_out) stalls++;
      chk("st_wb_rw", wb_RegWrite, 0);
      if (!mem_req) break;
    end
    chk("st_stall_cycles", stalls, 2);

    rdata_fixed = 1;
    rdata_val = 32'h80FF7F01;
    for (int i = 0; i < 5; i++) begin
      op = '0; op.mr = 1; op.m2r = 1; op.rw = 1; op.dest = 7; op.lm = lm_t[i];
      op.alu = 32'h200 + off_t[i];
      wait_q.push_back(0);
      issue(op, 0);
      cycle();
      cycle();
      chk("ld_wb_rw", wb_RegWrite, 1);
      chk("ld_data", wb_read_data, exp_t[i]);
    end
    rdata_fixed = 0;

    op = '0; op.br = 1; op.z = 1; op.pc = 32'h40;
    issue(op, 0);
    cycle();
    chk("br_taken", pc_src_out, 1);
    chk("br_target", branch_target_out, 32'h40);
    op.z = 0;
    issue(op, 0);
    cycle();
    chk("br_not_taken", pc_src_out, 0);

    op = '0; op.mr = 1; op.m2r = 1; op.rw = 1; op.dest = 3; op.alu = 32'h300;
    wait_q.push_back(0);
    issue(op, 0);
    op.alu = 32'h304;
    wait_q.push_back(0);
    issue(op, 0);
    chk("b2b_req_a", mem_req, 1);
    chk("b2b_addr_a", mem_addr, 32'h300);
    chk("b2b_stall_a", stall_out, 0);
    cycle();
    chk("b2b_req_b", mem_req, 1);
    chk("b2b_addr_b", mem_addr, 32'h304);
    chk("b2b_stall_b", stall_out, 0);
    cycle();

    op = '0; op.mr = 1; op.m2r = 1; op.rw = 1; op.dest = 9; op.alu = 32'h400;
    wait_q.push_back(3);
    issue(op, 0);
    cycle();
    chk("abort_waiting", stall_out, 1);
    rst_next = 0;
    cycle();
    rst_next = 1;
    cycle();
    chk("abort_req", mem_req, 0);
    chk("abort_stall", stall_out, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("abort_no_wb", wb_RegWrite, 0);
    end

    op = '0; op.mr = 1; op.m2r = 1; op.rw = 1; op.dest = 4; op.alu = 32'h500;
    issue(op, 1);
    cycle();
    chk("flush_no_req", mem_req, 0);
    cycle();
    chk("flush_no_wb", wb_RegWrite, 0);

    for (int i = 0; i < 3000; i++) begin
      ex_next = rand_op();
      flush_next = ($urandom_range(0, 7) == 0);
      rst_next = ($urandom_range(0, 80) != 0);
      cycle();
    end
    rst_next = 1;
    flush_next = 0;
    ex_next = '0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
